// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: PC loop, redirect strobes, instruction memory and decode handshakes.
// Signal names match the existing core's top-level nets.
interface instr_fetch_unit_if;
    logic [31:0] IF_PC_IN;
    logic [31:0] IF_PC_NEXT;
    logic        IF_STALL;
    logic        IF_BR_TAKEN;
    logic [31:0] IF_BR_TARGET;
    logic        IF_JUMP;
    logic [31:0] IF_JUMP_TARGET;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK;
    logic [31:0] IMEM_RDATA;
    logic        IF_VALID;
    logic        IF_READY;
    logic [31:0] IF_INSTR;
    logic [31:0] IF_INSTR_PC;
    logic        IF_MISALIGN;

    modport master (
        input  IF_PC_IN, IF_STALL, IF_BR_TAKEN, IF_BR_TARGET, IF_JUMP, IF_JUMP_TARGET,
               IMEM_ACK, IMEM_RDATA, IF_READY,
        output IF_PC_NEXT, IMEM_REQ, IMEM_ADDR, IF_VALID, IF_INSTR, IF_INSTR_PC, IF_MISALIGN
    );

    modport slave (
        output IF_PC_IN, IF_STALL, IF_BR_TAKEN, IF_BR_TARGET, IF_JUMP, IF_JUMP_TARGET,
               IMEM_ACK, IMEM_RDATA, IF_READY,
        input  IF_PC_NEXT, IMEM_REQ, IMEM_ADDR, IF_VALID, IF_INSTR, IF_INSTR_PC, IF_MISALIGN
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: next-PC generation, imem req/ack, decode valid/ready, redirects.
// Optional IF_ALIGN_CHECK_EN: misaligned redirect targets trap into a sticky error state.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                PC_CLK,
    input logic                PC_RST,
    instr_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {StIdle, StReq, StHold, StErr} state_e;

    state_e      state_q, state_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        misalign_q, misalign_d;

    logic        redir;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic        misalign_hit;
    logic [31:0] pc_next;

    assign redir      = bus.IF_BR_TAKEN | bus.IF_JUMP;
    assign target_raw = bus.IF_BR_TAKEN ? bus.IF_BR_TARGET : bus.IF_JUMP_TARGET;

`ifdef IF_ALIGN_CHECK_EN
    assign target       = target_raw;
    assign misalign_hit = redir && (target_raw[1:0] != 2'b00);
`else
    assign target       = {target_raw[31:2], 2'b00};
    assign misalign_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        misalign_d = misalign_q;
        pc_next    = bus.IF_PC_IN;

        if (misalign_hit && (state_q != StErr)) begin
            misalign_d = 1'b1;
            valid_d    = 1'b0;
            pend_d     = 1'b0;
            state_d    = StErr;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (redir) pc_next = target;
                    if (!bus.IF_STALL) state_d = StReq;
                end
                StReq: begin
                    if (bus.IMEM_ACK) begin
                        if (redir) begin
                            pc_next = target;
                            pend_d  = 1'b0;
                        end else if (pend_q) begin
                            pc_next = pend_pc_q;
                            pend_d  = 1'b0;
                        end else begin
                            instr_d    = bus.IMEM_RDATA;
                            instr_pc_d = bus.IF_PC_IN;
                            valid_d    = 1'b1;
                            pc_next    = bus.IF_PC_IN + 32'd4;
                            state_d    = StHold;
                        end
                    end else if (redir) begin
                        // PC must stay on the in-flight address; apply the redirect at ACK.
                        pend_d    = 1'b1;
                        pend_pc_d = target;
                    end
                end
                StHold: begin
                    if (redir || bus.IF_READY) begin
                        valid_d = 1'b0;
                        if (redir) pc_next = target;
                        state_d = bus.IF_STALL ? StIdle : StReq;
                    end
                end
                StErr: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge PC_CLK or negedge PC_RST) begin
        if (!PC_RST) begin
            state_q    <= StIdle;
            pend_q     <= 1'b0;
            pend_pc_q  <= 32'h0;
            valid_q    <= 1'b0;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.IF_PC_NEXT  = pc_next;
    assign bus.IMEM_REQ    = (state_q == StReq);
    assign bus.IMEM_ADDR   = bus.IF_PC_IN;
    assign bus.IF_VALID    = valid_q;
    assign bus.IF_INSTR    = instr_q;
    assign bus.IF_INSTR_PC = instr_pc_q;

    // RESET_PC is realised by the external PC register; the sequencer just fetches IF_PC_IN.
`ifdef IF_ALIGN_CHECK_EN
    assign bus.IF_MISALIGN = misalign_q;
    logic unused_bits;
    assign unused_bits = ^RESET_PC;
`else
    assign bus.IF_MISALIGN = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{RESET_PC, target_raw[1:0], misalign_q};
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios, then randomized traffic against a word-level
// model (next delivered word = last redirect target or previous word + 4).
module tb_instr_fetch_unit;

    localparam logic [31:0] ResetPc = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if ifc ();

    instr_fetch_unit #(.RESET_PC(ResetPc)) dut (
        .PC_CLK (clk),
        .PC_RST (rst_n),
        .bus    (ifc)
    );

    // Program counter register loaded every cycle from IF_PC_NEXT.
    logic [31:0] pc_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= ResetPc;
        else        pc_q <= ifc.IF_PC_NEXT;
    end
    assign ifc.IF_PC_IN = pc_q;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2008_0005;
    endfunction

    logic mem_auto = 1'b0;
    logic man_ack  = 1'b0;
    logic auto_ack = 1'b0;
    assign ifc.IMEM_ACK   = mem_auto ? auto_ack : man_ack;
    assign ifc.IMEM_RDATA = mem_word(ifc.IMEM_ADDR);

    // Random-latency memory (0..3 wait cycles) with occasional stray ACKs outside requests.
    int unsigned wait_left = 0;
    bit          fresh = 1'b1;
    always @(posedge clk) begin
        #1;
        if (!mem_auto || !ifc.IMEM_REQ) begin
            auto_ack = mem_auto && ($urandom_range(7) == 0);
            fresh    = 1'b1;
        end else begin
            if (fresh) wait_left = $urandom_range(3);
            auto_ack = (wait_left == 0);
            fresh    = auto_ack;
            if (wait_left != 0) wait_left--;
        end
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   n_accept = 0;
    bit   err_model = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic expect_from(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        exp_q.delete();
        exp_q.push_back(e);
    endtask

    // Monitor: every word decode accepts must be the model's next expected word.
    always @(negedge clk) begin
        exp_t e;
        exp_t nx;
        if (rst_n && ifc.IF_VALID && ifc.IF_READY) begin
            n_accept++;
            if (exp_q.size() == 0) begin
                chk("sb unexpected word", ifc.IF_INSTR_PC, 32'hDEAD_BEEF);
            end else begin
                e = exp_q.pop_front();
                chk("sb pc", ifc.IF_INSTR_PC, e.pc);
                chk("sb instr", ifc.IF_INSTR, e.instr);
                nx.pc    = e.pc + 32'd4;
                nx.instr = mem_word(nx.pc);
                exp_q.push_back(nx);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic ack, input logic br, input logic [31:0] bt,
                          input logic jp, input logic [31:0] jt, input logic rdy,
                          input logic st);
        logic [31:0] t;
        man_ack            = ack;
        ifc.IF_BR_TAKEN    = br;
        ifc.IF_BR_TARGET   = bt;
        ifc.IF_JUMP        = jp;
        ifc.IF_JUMP_TARGET = jt;
        ifc.IF_READY       = rdy;
        ifc.IF_STALL       = st;
        if ((br || jp) && !err_model) begin
            t = br ? bt : jt;
`ifdef IF_ALIGN_CHECK_EN
            if (t[1:0] != 2'b00) begin
                exp_q.delete();
                err_model = 1'b1;
            end else begin
                expect_from(t);
            end
`else
            expect_from({t[31:2], 2'b00});
`endif
        end
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst_n     = 1'b0;
        err_model = 1'b0;
        expect_from(ResetPc);
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int idle_cnt;
        int last_acc;
        logic br, jp, st, rdy;
        logic [31:0] bt, jt;

        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        expect_from(ResetPc);
        repeat (3) tick();
        #1;
        chk1("rst req", ifc.IMEM_REQ, 1'b0);
        chk1("rst valid", ifc.IF_VALID, 1'b0);
        chk("rst instr", ifc.IF_INSTR, 32'h0);
        chk("rst instr_pc", ifc.IF_INSTR_PC, 32'h0);
        chk1("rst misalign", ifc.IF_MISALIGN, 1'b0);
        chk("rst addr", ifc.IMEM_ADDR, 32'h0);
        chk("rst pc_next", ifc.IF_PC_NEXT, 32'h0);
        tick();
        rst_n = 1'b1;

        // Zero-wait fetch from reset, back-to-back with READY held.
        tick(); set_in(1, 0, 0, 0, 0, 1, 0); #1;
        chk1("t1 req", ifc.IMEM_REQ, 1'b1);
        chk("t1 addr", ifc.IMEM_ADDR, 32'h0);
        chk("t1 pc_next", ifc.IF_PC_NEXT, 32'h4);
        tick(); set_in(0, 0, 0, 0, 0, 1, 0); #1;
        chk1("t1 valid", ifc.IF_VALID, 1'b1);
        chk("t1 instr", ifc.IF_INSTR, 32'h2008_0005);
        chk("t1 instr_pc", ifc.IF_INSTR_PC, 32'h0);
        chk1("t1 hold req", ifc.IMEM_REQ, 1'b0);
        tick(); set_in(1, 0, 0, 0, 0, 1, 0); #1;
        chk1("t1 req2", ifc.IMEM_REQ, 1'b1);
        chk("t1 addr2", ifc.IMEM_ADDR, 32'h4);
        chk1("t1 valid gap", ifc.IF_VALID, 1'b0);
        tick(); set_in(0, 0, 0, 0, 0, 1, 0); #1;
        chk1("t1 valid2", ifc.IF_VALID, 1'b1);
        chk("t1 instr_pc2", ifc.IF_INSTR_PC, 32'h4);

        // Delayed ACK with a branch in the second wait cycle.
        tick(); set_in(0, 0, 0, 0, 0, 1, 0); #1;
        chk("t2 addr w1", ifc.IMEM_ADDR, 32'h8);
        tick(); set_in(0, 1, 32'h100, 0, 0, 0, 0); #1;
        chk("t2 addr w2", ifc.IMEM_ADDR, 32'h8);
        chk("t2 pc held", ifc.IF_PC_NEXT, 32'h8);
        tick(); set_in(0, 0, 0, 0, 0, 1, 0); #1;
        chk("t2 addr w3", ifc.IMEM_ADDR, 32'h8);
        chk1("t2 valid w3", ifc.IF_VALID, 1'b0);
        tick(); set_in(1, 0, 0, 0, 0, 1, 0); #1;
        chk("t2 addr ack", ifc.IMEM_ADDR, 32'h8);
        chk("t2 pc_next ack", ifc.IF_PC_NEXT, 32'h100);
        tick(); set_in(1, 0, 0, 0, 0, 1, 0); #1;
        chk("t2 redirected addr", ifc.IMEM_ADDR, 32'h100);
        chk1("t2 valid after discard", ifc.IF_VALID, 1'b0);

        // Branch and jump together in HOLD: branch wins.
        tick(); set_in(0, 1, 32'h40, 1, 32'h80, 0, 0); #1;
        chk("t3 instr_pc", ifc.IF_INSTR_PC, 32'h100);
        chk("t3 pc_next", ifc.IF_PC_NEXT, 32'h40);
        tick(); set_in(1, 0, 0, 0, 0, 1, 0); #1;
        chk1("t3 valid drop", ifc.IF_VALID, 1'b0);
        chk("t3 addr", ifc.IMEM_ADDR, 32'h40);

        // Stall in HOLD with READY: word accepted, no request until stall falls.
        tick(); set_in(0, 0, 0, 0, 0, 1, 1); #1;
        chk1("t4 valid", ifc.IF_VALID, 1'b1);
        tick(); set_in(0, 0, 0, 0, 0, 1, 1); #1;
        chk1("t4 valid clr", ifc.IF_VALID, 1'b0);
        chk1("t4 req stalled", ifc.IMEM_REQ, 1'b0);
        tick(); set_in(0, 0, 0, 0, 0, 1, 0); #1;
        chk1("t4 req stalled2", ifc.IMEM_REQ, 1'b0);
        tick(); set_in(1, 0, 0, 0, 0, 1, 0); #1;
        chk1("t4 req resume", ifc.IMEM_REQ, 1'b1);
        chk("t4 addr", ifc.IMEM_ADDR, 32'h44);
        tick(); set_in(0, 0, 0, 0, 0, 1, 0); #1;
        chk("t4 instr_pc", ifc.IF_INSTR_PC, 32'h44);

        // Jump to the top word, then wrap.
        tick(); set_in(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0); #1;
        chk("t5 pend hold", ifc.IF_PC_NEXT, 32'h48);
        tick(); set_in(1, 0, 0, 0, 0, 1, 0); #1;
        chk("t5 pend apply", ifc.IF_PC_NEXT, 32'hFFFF_FFFC);
        tick(); set_in(1, 0, 0, 0, 0, 1, 0); #1;
        chk("t5 addr top", ifc.IMEM_ADDR, 32'hFFFF_FFFC);
        chk("t5 wrap", ifc.IF_PC_NEXT, 32'h0);
        tick(); set_in(0, 0, 0, 0, 0, 1, 0); #1;
        chk("t5 instr_pc top", ifc.IF_INSTR_PC, 32'hFFFF_FFFC);
        tick(); set_in(0, 0, 0, 0, 0, 1, 0); #1;
        chk1("t5 req wrap", ifc.IMEM_REQ, 1'b1);
        chk("t5 addr wrap", ifc.IMEM_ADDR, 32'h0);

        // Reset mid-request, late ACK.
        rst_n = 1'b0;
        expect_from(ResetPc);
        #1;
        chk1("t5 req async drop", ifc.IMEM_REQ, 1'b0);
        tick(); set_in(1, 0, 0, 0, 0, 1, 0);
        rst_n = 1'b1;
        #1;
        chk1("t5 valid in rst", ifc.IF_VALID, 1'b0);
        tick(); set_in(0, 0, 0, 0, 0, 1, 0); #1;
        chk1("t5 late ack valid", ifc.IF_VALID, 1'b0);
        chk1("t5 req after rst", ifc.IMEM_REQ, 1'b1);
        tick(); set_in(1, 0, 0, 0, 0, 0, 0); #1;
        chk("t6 addr", ifc.IMEM_ADDR, 32'h0);

        // Misaligned jump target.
        tick(); set_in(0, 0, 0, 1, 32'h102, 0, 0); #1;
        chk("t6 instr_pc", ifc.IF_INSTR_PC, 32'h0);
`ifdef IF_ALIGN_CHECK_EN
        chk("t6 pc held", ifc.IF_PC_NEXT, 32'h4);
        repeat (3) begin
            tick(); set_in(1, 1, 32'h200, 0, 0, 1, 0); #1;
            chk1("t6 misalign", ifc.IF_MISALIGN, 1'b1);
            chk1("t6 no req", ifc.IMEM_REQ, 1'b0);
            chk1("t6 valid", ifc.IF_VALID, 1'b0);
            chk("t6 err pc held", ifc.IF_PC_NEXT, 32'h4);
        end
`else
        chk("t6 pc_next", ifc.IF_PC_NEXT, 32'h100);
        tick(); set_in(1, 0, 0, 0, 0, 1, 0); #1;
        chk1("t6 req", ifc.IMEM_REQ, 1'b1);
        chk("t6 addr aligned", ifc.IMEM_ADDR, 32'h100);
        chk1("t6 misalign", ifc.IF_MISALIGN, 1'b0);
        tick(); set_in(0, 0, 0, 0, 0, 1, 0); #1;
        chk("t6 instr_pc", ifc.IF_INSTR_PC, 32'h100);
`endif

        // Randomized traffic.
        do_reset();
        mem_auto = 1'b1;
        idle_cnt = 0;
        last_acc = n_accept;
        for (int i = 0; i < 3000; i++) begin
            tick();
            br = ($urandom_range(31) == 0);
            jp = ($urandom_range(31) == 0);
            bt = $urandom();
            jt = $urandom();
`ifdef IF_ALIGN_CHECK_EN
            bt[1:0] = 2'b00;
            jt[1:0] = 2'b00;
`endif
            st  = ($urandom_range(3) == 0);
            rdy = ($urandom_range(2) != 0) && !(br || jp);
            set_in(1'b0, br, bt, jp, jt, rdy, st);
            #1;
            chk("rand addr tracks pc", ifc.IMEM_ADDR, pc_q);
            if (n_accept == last_acc) idle_cnt++;
            else idle_cnt = 0;
            last_acc = n_accept;
            if (idle_cnt > 150) begin
                chk("rand progress timeout", 32'(idle_cnt), 32'd0);
                break;
            end
        end
        chk1("rand words delivered", n_accept > 200, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch sequencer for the 32-bit MIPS core. It produces the next-PC value that loads the program counter register, and runs a request/acknowledge handshake with instruction memory. It presents each fetched word to decode through a valid/ready handshake. It also applies branch and jump redirects, with the branch redirect taking priority.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset; must equal the program counter's reset value.

Ports:
- PC_CLK  in  1  clock, rising edge.
- PC_RST  in  1  asynchronous, active-low reset.
- IF_PC_IN  in  32  current PC, taken from the program counter register output.
- IF_PC_NEXT  out  32  next PC; drives the program counter input, which loads every cycle.
- IF_STALL  in  1  blocks issue of new memory requests.
- IF_BR_TAKEN  in  1  branch redirect strobe, one cycle.
- IF_BR_TARGET  in  32  branch target.
- IF_JUMP  in  1  jump redirect strobe, one cycle.
- IF_JUMP_TARGET  in  32  jump target.
- IMEM_REQ  out  1  instruction memory request.
- IMEM_ADDR  out  32  request address.
- IMEM_ACK  in  1  memory response strobe.
- IMEM_RDATA  in  32  instruction word; valid when IMEM_ACK=1.
- IF_VALID  out  1  IF_INSTR / IF_INSTR_PC hold a valid fetch.
- IF_READY  in  1  decode accepts the word.
- IF_INSTR  out  32  fetched instruction.
- IF_INSTR_PC  out  32  address of IF_INSTR.
- IF_MISALIGN  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- FSM states: IDLE, REQ, HOLD, ERR.
- Redirect rules:
  - Redirect = IF_BR_TAKEN | IF_JUMP; branch wins when both are asserted.
  - A redirect arriving while a request is outstanding sets pend=1 and latches the target into pend_pc.
  - Any new redirect overwrites pend_pc.
- IF_PC_NEXT = IF_PC_IN (hold) unless one of the cases below applies.
- IDLE:
  - IMEM_REQ=0.
  - Redirect → IF_PC_NEXT=target.
  - Goes to REQ when IF_STALL=0.
- REQ:
  - IMEM_REQ=1 and IMEM_ADDR=IF_PC_IN; the PC is held, so the address is stable until ACK.
  - On IMEM_ACK with a redirect this cycle, or pend=1: data discarded, IF_PC_NEXT=target (new redirect over pend_pc), pend cleared, stay in REQ.
  - On IMEM_ACK otherwise: IF_INSTR←IMEM_RDATA, IF_INSTR_PC←IF_PC_IN, IF_VALID←1, IF_PC_NEXT=IF_PC_IN+4, → HOLD.
- HOLD:
  - IMEM_REQ=0, IF_VALID=1.
  - Redirect → IF_VALID←0, IF_PC_NEXT=target, → REQ, or IDLE if IF_STALL.
  - Otherwise IF_READY → IF_VALID←0, → REQ, or IDLE if IF_STALL.
- IF_STALL never aborts an outstanding request. It does not affect IF_VALID.
- IMEM_ACK outside REQ is ignored.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC+4 = 32'h0000_0000.

## Timing
- Reset values:
  - state=IDLE, IMEM_REQ=0, IMEM_ADDR=IF_PC_IN.
  - IF_VALID=0, IF_INSTR=0, IF_INSTR_PC=0.
  - pend=0, pend_pc=0, IF_MISALIGN=0.
  - IF_PC_NEXT=IF_PC_IN.
- The first IMEM_REQ rises in the first cycle after reset release, at RESET_PC.
- IF_PC_NEXT, IMEM_REQ and IMEM_ADDR are combinational from state and inputs. All other outputs are registered.
- Zero-wait memory (ACK in the first REQ cycle): IF_VALID rises the next cycle. Back-to-back words arrive every 2 cycles with IF_READY held at 1.
- A redirect takes effect on the PC in the same cycle when no request is outstanding. Otherwise it takes effect in the ACK cycle.
- Reset asserted mid-request: IMEM_REQ drops asynchronously and pending state is lost. A late ACK is ignored.

## Configuration
- IF_ALIGN_CHECK_EN defined:
  - A selected redirect target with [1:0]≠0 is not applied.
  - IF_MISALIGN←1 (sticky until reset), IF_VALID←0, → ERR.
  - ERR: IMEM_REQ=0, PC held, all inputs ignored.
- IF_ALIGN_CHECK_EN undefined:
  - Target bits [1:0] are forced to 2'b00.
  - IF_MISALIGN is tied 0 and ERR is unreachable.

## Test plan
- Reset release, zero-wait memory returning 32'h2008_0005, IF_READY=1 → IMEM_ADDR=0, then IF_INSTR=32'h2008_0005 with IF_INSTR_PC=0, then a request at 0x4.
- ACK delayed 3 cycles with IF_BR_TAKEN in the 2nd wait cycle (target 0x100) → IMEM_ADDR held at 0x8 until ACK, data discarded, next request at 0x100, IF_VALID stays 0.
- IF_BR_TAKEN (0x40) and IF_JUMP (0x80) in the same HOLD cycle → IF_VALID drops, next IMEM_ADDR=0x40.
- IF_STALL=1 in HOLD with IF_READY=1 → IF_VALID clears, IMEM_REQ stays 0 while stalled, then request at PC+4 the cycle after IF_STALL falls.
- PC=32'hFFFF_FFFC fetched → IF_PC_NEXT=0; PC_RST pulsed mid-REQ → IMEM_REQ=0 immediately, and a late ACK leaves IF_VALID=0.
- Jump to 0x102: with IF_ALIGN_CHECK_EN → IF_MISALIGN=1 and no further IMEM_REQ; without it → fetch at 0x100.
